spi_master_mc: RTL and testbench
================================

SPI_MASTER_MC -- requirements
Module: spi_master_mc

Interface
REQ-001 The block SHALL be synchronous to a single clock `clk`, with a synchronous active-high reset `reset`.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- D_WIDTH, 16: bits per transfer; legal range 2..32.
- N_CS, 2: number of chip-select lines; legal range 1..8.
- CLK_DIV, 2: clk cycles per SCLK half-period; legal minimum 1.
- LDAC_EN, 1: when 1, an LDAC pulse is issued after each transfer.
- LDAC_LEN, 2: ldac_n low width in clk cycles; legal minimum 1.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk, in, 1: system clock.
- reset, in, 1: synchronous, active-high.
- start, in, 1: transfer request; sampled only while busy=0.
- d_in, in, D_WIDTH: transmit word; captured when start is accepted.
- cs_sel, in, $clog2(N_CS) (min 1): target chip select; captured at start.
- cpol, in, 1: SCLK idle level; captured at start.
- cpha, in, 1: clock phase; captured at start.
- sclk, out, 1: SPI clock.
- mosi, out, 1: serial data out, MSB first.
- miso, in, 1: serial data in.
- cs_n, out, N_CS: active-low chip selects.
- ldac_n, out, 1: active-low DAC load strobe.
- busy, out, 1: transfer in progress.
- done, out, 1: one-cycle completion pulse.
- d_out, out, D_WIDTH: received word.

Function
REQ-004 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD, LDAC and DONE.
REQ-005 In IDLE, start=1 SHALL be accepted at that edge; busy, the selected cs_n bit low and the state SETUP SHALL all take effect from the next cycle.
REQ-006 At acceptance the block SHALL latch d_in, cs_sel, cpol and cpha; later changes to these inputs SHALL have no effect on the current transfer.
REQ-007 start SHALL be ignored while busy=1, with no queueing.
REQ-008 SETUP SHALL last CLK_DIV cycles with sclk=cpol; if cpha=0, mosi SHALL present the MSB for all of SETUP.
REQ-009 SHIFT SHALL generate 2*D_WIDTH SCLK edges, each CLK_DIV cycles apart, with the first edge at the SETUP-to-SHIFT boundary.
REQ-010 If cpha=0, miso SHALL be sampled on odd-numbered edges (leading) and mosi SHALL advance on even-numbered edges, except that mosi SHALL NOT advance after the final edge.
REQ-011 If cpha=1, mosi SHALL advance on odd-numbered edges, with the MSB driven on edge 1, and miso SHALL be sampled on even-numbered edges.
REQ-012 Received bits SHALL be shifted in MSB first, so the first sampled bit lands in d_out[D_WIDTH-1].
REQ-013 HOLD SHALL last CLK_DIV cycles with sclk=cpol and cs_n still asserted; all cs_n bits SHALL go high on exit from HOLD.
REQ-014 If LDAC_EN=1, the LDAC state SHALL drive ldac_n=0 for exactly LDAC_LEN cycles, with cs_n high; if LDAC_EN=0, the LDAC state SHALL be skipped and ldac_n SHALL be held at 1.
REQ-015 DONE SHALL last one cycle: busy=0, done=1, and d_out updated with the full received word.
REQ-016 The FSM SHALL return to IDLE after DONE, and start SHALL be acceptable in the DONE cycle.
REQ-017 busy SHALL stay high for exactly CLK_DIV*(2*D_WIDTH+2) + LDAC_EN*LDAC_LEN cycles.
REQ-018 d_out SHALL hold its value between done pulses and SHALL NOT show partial words.
REQ-019 If cs_sel >= N_CS, no cs_n bit SHALL assert, and the transfer timing and done pulse SHALL be otherwise unchanged.
REQ-020 When not busy, the outputs SHALL be: mosi=0, sclk equal to the last latched cpol, and all cs_n bits high.

Reset
REQ-021 reset=1 SHALL take priority over all other inputs, including when asserted mid-transfer.
REQ-022 At the next edge after reset is asserted, the block SHALL set: state=IDLE, sclk=0, mosi=0, cs_n all 1, ldac_n=1, busy=0, done=0, d_out=0, latched cpol=0.
REQ-023 No done pulse SHALL be generated for a transfer aborted by reset.

Verification
REQ-024 The bench SHALL cover the following directed scenarios (D_WIDTH=16, CLK_DIV=2, LDAC_EN=1, LDAC_LEN=2 unless noted):
- Mode 0, d_in=16'hA5A5, cs_sel=0, miso looped to mosi -> cs_n=2'b10 during the transfer, 16 rising edges on sclk, mosi sequence A5A5 MSB first, busy high for 70 cycles, ldac_n low for 2 cycles after cs_n rises, then done with d_out=16'hA5A5.
- Mode 3 (cpol=1, cpha=1), d_in=16'h1234, cs_sel=1, miso driven from a slave model sending 16'hBEEF -> sclk idles at 1, cs_n=2'b01, d_out=16'hBEEF at done.
- start pulsed again during busy, with d_in changed to 16'hFFFF -> ignored; mosi still carries the original word; exactly one done pulse.
- reset asserted at cycle 20 of a transfer -> the next cycle shows cs_n=2'b11, busy=0, sclk=0, ldac_n=1; no done pulse; a subsequent start works normally.
- Back-to-back: start held high through DONE -> the second transfer begins the cycle after done, with no idle gap beyond DONE.
- LDAC_EN=0, CLK_DIV=1, D_WIDTH=8, d_in=8'h3C -> busy high for 18 cycles, ldac_n constant 1, mosi pattern 00111100.

Source files
------------

// File: rtl/spi_master_mc.sv
// SPI master with selectable chip select, runtime CPOL/CPHA per transfer and an
// optional LDAC strobe after chip-select release.
module spi_master_mc #(
  parameter  int D_WIDTH  = 16,
  parameter  int N_CS     = 2,
  parameter  int CLK_DIV  = 2,
  parameter  int LDAC_EN  = 1,
  parameter  int LDAC_LEN = 2,
  localparam int CS_W     = (N_CS > 1) ? $clog2(N_CS) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [D_WIDTH-1:0] d_in,
  input  logic [CS_W-1:0]    cs_sel,
  input  logic               cpol,
  input  logic               cpha,
  output logic               sclk,
  output logic               mosi,
  input  logic               miso,
  output logic [N_CS-1:0]    cs_n,
  output logic               ldac_n,
  output logic               busy,
  output logic               done,
  output logic [D_WIDTH-1:0] d_out
);

  localparam int CNT_MAX = (CLK_DIV > LDAC_LEN) ? CLK_DIV : LDAC_LEN;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int EDGES   = 2 * D_WIDTH;
  localparam int EC_W    = $clog2(EDGES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, LDAC, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [EC_W-1:0]    edge_cnt, edge_nxt;
  logic [D_WIDTH-1:0] tx_sr, rx_sr;
  logic               cpha_q;
  logic               div_tick, ldac_tick, accept, last_edge;
  logic               edge_fire, drive, sample;

  always_comb begin
    div_tick  = (cnt == CNT_W'(CLK_DIV - 1));
    ldac_tick = (cnt == CNT_W'(LDAC_LEN - 1));
    accept    = start && (state == IDLE || state == DONE);
    last_edge = (edge_cnt == EC_W'(EDGES));
    edge_nxt  = edge_cnt + 1'b1;
    // Edge 1 fires on the SETUP->SHIFT boundary; the rest every CLK_DIV cycles.
    edge_fire = div_tick && (state == SETUP || (state == SHIFT && !last_edge));
    drive     = cpha_q ? edge_nxt[0] : (!edge_nxt[0] && edge_nxt != EC_W'(EDGES));
    sample    = cpha_q ? !edge_nxt[0] : edge_nxt[0];
    state_nxt = state;
    case (state)
      IDLE, DONE: state_nxt = accept ? SETUP : IDLE;
      SETUP:      if (div_tick) state_nxt = SHIFT;
      SHIFT:      if (div_tick && last_edge) state_nxt = HOLD;
      HOLD:       if (div_tick) state_nxt = (LDAC_EN != 0) ? LDAC : DONE;
      LDAC:       if (ldac_tick) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= '0;
      edge_cnt <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      cpha_q   <= 1'b0;
      sclk     <= 1'b0;
      mosi     <= 1'b0;
      cs_n     <= '1;
      ldac_n   <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      d_out    <= '0;
    end else begin
      done <= 1'b0;
      cnt  <= (state_nxt != state || state == IDLE || (state == SHIFT && div_tick))
              ? '0 : cnt + 1'b1;

      if (accept) begin
        cpha_q   <= cpha;
        busy     <= 1'b1;
        sclk     <= cpol;
        edge_cnt <= '0;
        // CPHA=0 presents the MSB for all of SETUP, so it leaves the shifter early.
        tx_sr    <= cpha ? d_in : (d_in << 1);
        mosi     <= cpha ? 1'b0 : d_in[D_WIDTH-1];
        for (int i = 0; i < N_CS; i++) cs_n[i] <= (int'(cs_sel) != i);
      end

      if (edge_fire) begin
        edge_cnt <= edge_nxt;
        sclk     <= ~sclk;
        if (drive) begin
          mosi  <= tx_sr[D_WIDTH-1];
          tx_sr <= tx_sr << 1;
        end
        if (sample) rx_sr <= {rx_sr[D_WIDTH-2:0], miso};
      end

      if (state == HOLD && div_tick) begin
        cs_n <= '1;
        mosi <= 1'b0;
        if (LDAC_EN != 0) ldac_n <= 1'b0;
      end

      if (state == LDAC && ldac_tick) ldac_n <= 1'b1;

      if (state_nxt == DONE && state != DONE) begin
        busy  <= 1'b0;
        done  <= 1'b1;
        d_out <= rx_sr;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_mc.sv
// Scoreboard bench: a behavioural SPI slave captures mosi and serves miso; done
// pulses are matched against queued expectations from the stimulus side.
module tb_spi_master_mc;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start0, cpol0, cpha0, miso0, sclk0, mosi0, ldac_n0, busy0, done0;
  logic [15:0] d_in0, d_out0;
  logic [0:0]  cs_sel0;
  logic [1:0]  cs_n0;

  logic        start1, cpol1, cpha1, sclk1, mosi1, ldac_n1, busy1, done1;
  logic [7:0]  d_in1, d_out1;
  logic [1:0]  cs_sel1;
  logic [2:0]  cs_n1;

  logic loop0;
  logic slave_miso = 1'b0;
  assign miso0 = loop0 ? mosi0 : slave_miso;

  spi_master_mc dut0 (
    .clk(clk), .reset(reset), .start(start0), .d_in(d_in0), .cs_sel(cs_sel0),
    .cpol(cpol0), .cpha(cpha0), .sclk(sclk0), .mosi(mosi0), .miso(miso0),
    .cs_n(cs_n0), .ldac_n(ldac_n0), .busy(busy0), .done(done0), .d_out(d_out0)
  );

  spi_master_mc #(.D_WIDTH(8), .N_CS(3), .CLK_DIV(1), .LDAC_EN(0), .LDAC_LEN(2)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .d_in(d_in1), .cs_sel(cs_sel1),
    .cpol(cpol1), .cpha(cpha1), .sclk(sclk1), .mosi(mosi1), .miso(mosi1),
    .cs_n(cs_n1), .ldac_n(ldac_n1), .busy(busy1), .done(done1), .d_out(d_out1)
  );

  int vectors = 0, miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] d;
    logic [15:0] rx;
    logic [1:0]  csn;
    logic        cpol, cpha;
  } exp_t;
  exp_t q[$];

  // Monitor + slave model for dut0
  logic rst_q = 1'b1;
  always @(posedge clk) rst_q <= reset;

  bit          active = 0, glitch = 0;
  exp_t        cur;
  logic [15:0] s_tx = '0, s_rx = '0, last_dout = '0;
  logic [1:0]  cs_first = '1;
  logic        prev_sclk = 1'b0;
  int          busy_cnt = 0, rises = 0, ldac_cnt = 0;

  always @(negedge clk) begin
    if (rst_q) begin
      active    = 0;
      glitch    = 0;
      last_dout = d_out0;
    end else begin
      if (d_out0 !== last_dout && !done0) glitch = 1;
      last_dout = d_out0;
      if (busy0 && !active && q.size() > 0) begin
        cur       = q[0];
        active    = 1;
        s_tx      = cur.rx;
        s_rx      = '0;
        prev_sclk = sclk0;
        busy_cnt  = 1;
        rises     = 0;
        ldac_cnt  = 0;
        cs_first  = cs_n0;
        check("sclk_setup", 32'(sclk0), 32'(cur.cpol));
        if (!cur.cpha) begin
          slave_miso = s_tx[15];
          s_tx = s_tx << 1;
        end
      end else if (active && busy0) begin
        busy_cnt++;
        if (!ldac_n0 && cs_n0 == 2'b11) ldac_cnt++;
        if (sclk0 != prev_sclk) begin
          if (sclk0) rises++;
          if ((sclk0 != cur.cpol) == (cur.cpha == 1'b0)) s_rx = {s_rx[14:0], mosi0};
          else begin
            slave_miso = s_tx[15];
            s_tx = s_tx << 1;
          end
        end
        prev_sclk = sclk0;
      end
      if (done0) begin
        check("done_has_txn", 32'(active && q.size() > 0), 32'd1);
        if (active && q.size() > 0) begin
          void'(q.pop_front());
          check("d_out", 32'(d_out0), 32'(cur.rx));
          check("mosi_word", 32'(s_rx), 32'(cur.d));
          check("busy_len", 32'(busy_cnt), 32'd70);
          check("sclk_rises", 32'(rises), 32'd16);
          check("ldac_len", 32'(ldac_cnt), 32'd2);
          check("cs_n_active", 32'(cs_first), 32'(cur.csn));
          check("sclk_idle", 32'(sclk0), 32'(cur.cpol));
          check("done_cs_n", 32'(cs_n0), 32'h3);
          check("d_out_stable", 32'(glitch), 32'd0);
          active = 0;
        end
      end
    end
  end

  task automatic wait_idle0();
    int n = 0;
    while (busy0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 32'(busy0), 32'd0);
  endtask

  // Called at a negedge with busy0 low, so the start is accepted at the next edge.
  task automatic issue(input logic [15:0] d, input logic [0:0] cs, input logic pol, pha,
                       input logic [15:0] sw, input bit lp, input bit hold);
    exp_t e;
    e.d = d; e.rx = lp ? d : sw; e.csn = cs ? 2'b01 : 2'b10; e.cpol = pol; e.cpha = pha;
    d_in0 = d; cs_sel0 = cs; cpol0 = pol; cpha0 = pha; loop0 = lp; start0 = 1'b1;
    q.push_back(e);
    @(negedge clk);
    check("accept_busy", 32'(busy0), 32'd1);
    check("accept_cs_n", 32'(cs_n0), 32'(e.csn));
    if (!hold) start0 = 1'b0;
    d_in0 = 16'($urandom); cs_sel0 = 1'($urandom); cpol0 = 1'($urandom); cpha0 = 1'($urandom);
  endtask

  task automatic run1(input logic [7:0] d, input logic [1:0] cs, input logic [2:0] exp_csn);
    int bc = 0, n = 0;
    bit ldac_hi = 1, cs_ok = 1;
    logic [7:0] mos = '0;
    logic ps;
    d_in1 = d; cs_sel1 = cs; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0; d_in1 = 8'hFF;
    ps = sclk1;
    while (busy1 && n < 100) begin
      bc++;
      if (!ldac_n1) ldac_hi = 0;
      if (cs_n1 !== exp_csn) cs_ok = 0;
      if (sclk1 && !ps) mos = {mos[6:0], mosi1};
      ps = sclk1;
      @(negedge clk);
      n++;
    end
    check("d1_busy_len", 32'(bc), 32'd18);
    check("d1_ldac_const", 32'(ldac_hi && ldac_n1), 32'd1);
    check("d1_mosi_pattern", 32'(mos), 32'(d));
    check("d1_cs_n", 32'(cs_ok), 32'd1);
    check("d1_done", 32'(done1), 32'd1);
    check("d1_d_out", 32'(d_out1), 32'(d));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; start0 = 1'b0; start1 = 1'b0; loop0 = 1'b0;
    d_in0 = '0; cs_sel0 = '0; cpol0 = 1'b1; cpha0 = 1'b0;
    d_in1 = '0; cs_sel1 = '0; cpol1 = 1'b0; cpha1 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_cs_n", 32'(cs_n0), 32'h3);
    check("rst_sclk", 32'(sclk0), 32'd0);
    check("rst_mosi", 32'(mosi0), 32'd0);
    check("rst_ldac", 32'(ldac_n0), 32'd1);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_d_out", 32'(d_out0), 32'd0);
    check("rst1_cs_n", 32'(cs_n1), 32'h7);
    reset = 1'b0;
    @(negedge clk);

    issue(16'hA5A5, 1'b0, 1'b0, 1'b0, 16'h0000, 1, 0); wait_idle0();
    @(negedge clk);
    issue(16'h1234, 1'b1, 1'b1, 1'b1, 16'hBEEF, 0, 0); wait_idle0();
    @(negedge clk);
    check("mode3_idle_sclk", 32'(sclk0), 32'd1);

    // start during busy with a new word must be dropped
    issue(16'h5A0F, 1'b0, 1'b0, 1'b1, 16'h0F0F, 0, 0);
    repeat (10) @(negedge clk);
    start0 = 1'b1; d_in0 = 16'hFFFF;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle0();
    @(negedge clk);

    // reset mid-transfer aborts without a done pulse
    issue(16'hC3C3, 1'b1, 1'b0, 1'b0, 16'h9999, 0, 0);
    repeat (19) @(negedge clk);
    reset = 1'b1;
    q.delete();
    @(negedge clk);
    reset = 1'b0;
    check("abort_cs_n", 32'(cs_n0), 32'h3);
    check("abort_busy", 32'(busy0), 32'd0);
    check("abort_sclk", 32'(sclk0), 32'd0);
    check("abort_ldac", 32'(ldac_n0), 32'd1);
    check("abort_done", 32'(done0), 32'd0);
    repeat (80) @(negedge clk);
    check("abort_idle", 32'(busy0), 32'd0);

    // back-to-back with start held through DONE
    issue(16'h8001, 1'b0, 1'b0, 1'b0, 16'h7FFE, 0, 1); wait_idle0();
    check("b2b_done1", 32'(done0), 32'd1);
    issue(16'h0FF0, 1'b1, 1'b1, 1'b0, 16'hCAFE, 0, 1); wait_idle0();
    check("b2b_done2", 32'(done0), 32'd1);
    issue(16'hF00F, 1'b0, 1'b0, 1'b1, 16'h1357, 0, 0); wait_idle0();

    for (int i = 0; i < 30; i++) begin
      issue(16'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom),
            0, (i < 29) ? bit'($urandom_range(0, 1)) : 1'b0);
      wait_idle0();
      if (!start0) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    repeat (3) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);

    run1(8'h3C, 2'd0, 3'b110);
    @(negedge clk);
    run1(8'hA6, 2'd3, 3'b111);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
